// File: rtl/ram_port_arbiter_if.sv
// Signal bundle between the RAM port arbiter and its environment (two requesters plus the RAM).
// Carries only wires; no latency of its own.
// Requesters hold req until granted; the RAM side has no backpressure.
interface ram_port_arbiter_if #(
    parameter int ADDR_WIDTH = 14,
    parameter int DATA_WIDTH = 16
);
    logic                    a_req;
    logic [ADDR_WIDTH-1:0]   a_addr;
    logic [DATA_WIDTH-1:0]   a_din;
    logic [DATA_WIDTH/8-1:0] a_write_en;
    logic                    a_grant;
    logic                    a_rd_valid;
    logic [DATA_WIDTH-1:0]   a_dout;

    logic                    b_req;
    logic [ADDR_WIDTH-1:0]   b_addr;
    logic [DATA_WIDTH-1:0]   b_din;
    logic [DATA_WIDTH/8-1:0] b_write_en;
    logic                    b_grant;
    logic                    b_rd_valid;
    logic [DATA_WIDTH-1:0]   b_dout;

    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_din;
    logic [DATA_WIDTH/8-1:0] ram_write_en;
    logic [DATA_WIDTH-1:0]   ram_dout;

    // Environment side: requesters and the RAM.
    modport master (
        output a_req, a_addr, a_din, a_write_en,
        output b_req, b_addr, b_din, b_write_en,
        output ram_dout,
        input  a_grant, a_rd_valid, a_dout,
        input  b_grant, b_rd_valid, b_dout,
        input  ram_addr, ram_din, ram_write_en
    );

    // Arbiter side.
    modport slave (
        input  a_req, a_addr, a_din, a_write_en,
        input  b_req, b_addr, b_din, b_write_en,
        input  ram_dout,
        output a_grant, a_rd_valid, a_dout,
        output b_grant, b_rd_valid, b_dout,
        output ram_addr, ram_din, ram_write_en
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter/sequencer in front of a byte-writable single-port RAM.
// Grant is combinational; command registered next cycle; read data + rd_valid two cycles after grant.
// A denied requester simply keeps req high; fixed-priority mode forces B through after MAX_WAIT denials.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 16,
    parameter int FIXED_PRIO_A = 0,
    parameter int MAX_WAIT     = 7
) (
    input  logic                clk,
    input  logic                reset,
    ram_port_arbiter_if.slave   bus
);
    localparam int BE_WIDTH = DATA_WIDTH / 8;
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic                  grant_a;
    logic                  grant_b;
    logic                  last_win;      // 1 = B won the most recent grant
    logic [7:0]            starve_cnt;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] din_q;
    logic [BE_WIDTH-1:0]   we_q;

    // Tag pipe: stage 1 holds {is_read, owner}; stage 2 is kept decoded per owner
    // so each rd_valid comes straight from a flop.
    logic                  tag1_rd;
    logic                  tag1_owner;    // 1 = B
    logic                  rd_valid_a_q;
    logic                  rd_valid_b_q;

    // Pick at most one winner this cycle; nothing is granted while reset is held.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!reset) begin
            if (bus.a_req && bus.b_req) begin
                if (FIXED_PRIO_A != 0) begin
                    if (starve_cnt == MAX_WAIT_C) grant_b = 1'b1;
                    else                          grant_a = 1'b1;
                end else begin
                    if (last_win) grant_a = 1'b1;
                    else          grant_b = 1'b1;
                end
            end else if (bus.a_req) begin
                grant_a = 1'b1;
            end else if (bus.b_req) begin
                grant_b = 1'b1;
            end
        end
    end

    // Register the winning command; an idle cycle drops the byte enables but keeps addr/din.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            din_q  <= '0;
            we_q   <= '0;
        end else if (grant_a) begin
            addr_q <= bus.a_addr;
            din_q  <= bus.a_din;
            we_q   <= bus.a_write_en;
        end else if (grant_b) begin
            addr_q <= bus.b_addr;
            din_q  <= bus.b_din;
            we_q   <= bus.b_write_en;
        end else begin
            we_q   <= '0;
        end
    end

    // Track read ownership two stages deep so returning data reaches only its issuer.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag1_rd      <= 1'b0;
            tag1_owner   <= 1'b0;
            rd_valid_a_q <= 1'b0;
            rd_valid_b_q <= 1'b0;
        end else begin
            tag1_rd      <= (grant_a && (bus.a_write_en == '0)) ||
                            (grant_b && (bus.b_write_en == '0));
            tag1_owner   <= grant_b;
            rd_valid_a_q <= tag1_rd && !tag1_owner;
            rd_valid_b_q <= tag1_rd &&  tag1_owner;
        end
    end

    // Remember the last winner for round-robin tie breaking; untouched on idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        last_win <= 1'b1;
        else if (grant_a) last_win <= 1'b0;
        else if (grant_b) last_win <= 1'b1;
    end

    // Count consecutive B denials in fixed-priority mode, saturating at the guard limit.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (FIXED_PRIO_A == 0) begin
            starve_cnt <= '0;
        end else if (!bus.b_req || grant_b) begin
            starve_cnt <= '0;
        end else if (starve_cnt != MAX_WAIT_C) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    assign bus.a_grant      = grant_a;
    assign bus.b_grant      = grant_b;
    assign bus.ram_addr     = addr_q;
    assign bus.ram_din      = din_q;
    assign bus.ram_write_en = we_q;
    assign bus.a_rd_valid   = rd_valid_a_q;
    assign bus.b_rd_valid   = rd_valid_b_q;
    // Both requesters see the raw RAM output; rd_valid alone says whose it is.
    assign bus.a_dout       = bus.ram_dout;
    assign bus.b_dout       = bus.ram_dout;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed per-cycle vectors, read results checked by a scoreboard.
// Expected read data and return cycle are queued at grant time and popped by a monitor.
// A second instance exercises fixed-priority mode with a starvation limit of 3.
module tb_ram_port_arbiter;
    localparam int AW = 14;
    localparam int DW = 16;

    typedef struct {
        logic          owner;   // 1 = B
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    logic track;

    exp_t sb[$];

    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    logic [1:0]    exp_we;

    logic [DW-1:0] mem [0:(1<<AW)-1];
    logic [DW-1:0] ram_q;
    logic          preload;

    ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    ram_port_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus2 ();

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO_A(0), .MAX_WAIT(7)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIO_A(1), .MAX_WAIT(3)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural RAM: one-cycle registered read, byte-masked write; preloaded on the first edge.
    always @(posedge clk) begin
        if (preload) begin
            mem[14'h0001] = 16'h1111;
            mem[14'h0002] = 16'h2222;
            mem[14'h0010] = 16'hDEAD;
            mem[14'h0040] = 16'h1234;
            mem[14'h0123] = 16'hBEEF;
        end
        ram_q <= mem[bus.ram_addr];
        for (int i = 0; i < 2; i++)
            if (bus.ram_write_en[i]) mem[bus.ram_addr][i*8 +: 8] = bus.ram_din[i*8 +: 8];
    end
    assign bus.ram_dout  = ram_q;
    assign bus2.ram_dout = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Read-return monitor: every rd_valid must match the oldest queued read.
    always @(negedge clk) begin
        if (bus.a_rd_valid || bus.b_rd_valid) begin
            if (bus.a_rd_valid && bus.b_rd_valid) begin
                chk("rd_valid_both", {bus.b_rd_valid, bus.a_rd_valid}, 32'h0);
            end else if (sb.size() == 0) begin
                chk("rd_valid_unexpected", {bus.b_rd_valid, bus.a_rd_valid}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_owner", {31'd0, bus.b_rd_valid}, {31'd0, e.owner});
                chk("rd_data", bus.b_rd_valid ? bus.b_dout : bus.a_dout, e.data);
                chk("rd_cycle", cyc, e.cyc);
            end
        end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
            exp_t e;
            e = sb.pop_front();
            chk("rd_missing", 32'h0, 32'h1);
        end
    end

    // One cycle of stimulus: drive both requesters, check the registered command from the
    // previous cycle, check the grant, then advance the expected command/read model.
    task automatic step(input logic ar, input logic [AW-1:0] aa, input logic [DW-1:0] ad, input logic [1:0] aw,
                        input logic br, input logic [AW-1:0] ba, input logic [DW-1:0] bd, input logic [1:0] bw,
                        input logic [1:0] eg, input logic [DW-1:0] erd);
        @(posedge clk); #1;
        bus.a_req = ar; bus.a_addr = aa; bus.a_din = ad; bus.a_write_en = aw;
        bus.b_req = br; bus.b_addr = ba; bus.b_din = bd; bus.b_write_en = bw;
        @(negedge clk);
        chk("ram_write_en", {30'd0, bus.ram_write_en}, {30'd0, exp_we});
        chk("ram_addr", {18'd0, bus.ram_addr}, {18'd0, exp_addr});
        chk("ram_din", {16'd0, bus.ram_din}, {16'd0, exp_din});
        chk("grant", {30'd0, bus.b_grant, bus.a_grant}, {30'd0, eg});
        if (eg == 2'b01) begin
            exp_addr = aa; exp_din = ad; exp_we = aw;
            if (aw == 2'b00 && track) sb.push_back('{1'b0, erd, cyc + 2});
        end else if (eg == 2'b10) begin
            exp_addr = ba; exp_din = bd; exp_we = bw;
            if (bw == 2'b00 && track) sb.push_back('{1'b1, erd, cyc + 2});
        end else begin
            exp_we = 2'b00;
        end
    endtask

    task automatic idle();
        step(1'b0, '0, '0, 2'b00, 1'b0, '0, '0, 2'b00, 2'b00, '0);
    endtask

    task automatic clear_reqs();
        bus.a_req = 1'b0; bus.a_addr = '0; bus.a_din = '0; bus.a_write_en = '0;
        bus.b_req = 1'b0; bus.b_addr = '0; bus.b_din = '0; bus.b_write_en = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        track   = 1'b1;
        preload = 1'b1;
        reset   = 1'b1;
        clear_reqs();
        bus.a_req = 1'b1;                         // must not be granted under reset
        bus2.a_req = 1'b0; bus2.a_addr = '0; bus2.a_din = '0; bus2.a_write_en = '0;
        bus2.b_req = 1'b0; bus2.b_addr = '0; bus2.b_din = '0; bus2.b_write_en = '0;
        exp_addr = '0; exp_din = '0; exp_we = '0;

        // Reset state
        @(negedge clk);
        preload = 1'b0;
        chk("reset_a_grant", {31'd0, bus.a_grant}, 32'h0);
        chk("reset_ram_write_en", {30'd0, bus.ram_write_en}, 32'h0);
        chk("reset_ram_addr", {18'd0, bus.ram_addr}, 32'h0);
        chk("reset_rd_valid", {30'd0, bus.b_rd_valid, bus.a_rd_valid}, 32'h0);
        clear_reqs();
        @(posedge clk); #1;
        reset = 1'b0;

        // Round-robin contention: A first after reset, then strict alternation.
        for (int i = 0; i < 6; i++)
            step(1'b1, 14'h0001, '0, 2'b00, 1'b1, 14'h0002, '0, 2'b00,
                 (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 16'h1111 : 16'h2222);
        idle(); idle();

        // Single read from A
        step(1'b1, 14'h0123, '0, 2'b00, 1'b0, '0, '0, 2'b00, 2'b01, 16'hBEEF);
        idle(); idle();

        // Byte write from B (low byte only), then read it back
        step(1'b0, '0, '0, 2'b00, 1'b1, 14'h0040, 16'h00AA, 2'b01, 2'b10, '0);
        step(1'b0, '0, '0, 2'b00, 1'b1, 14'h0040, '0, 2'b00, 2'b10, 16'h12AA);
        idle(); idle();

        // Single-cycle A writes separated by idle cycles
        step(1'b1, 14'h0050, 16'h5555, 2'b11, 1'b0, '0, '0, 2'b00, 2'b01, '0);
        idle();
        step(1'b1, 14'h0051, 16'h6666, 2'b10, 1'b0, '0, '0, 2'b00, 2'b01, '0);
        idle(); idle();

        // Reset while a read of 0x0010 is in flight: it must never return.
        track = 1'b0;
        step(1'b1, 14'h0010, '0, 2'b00, 1'b0, '0, '0, 2'b00, 2'b01, '0);
        track = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        clear_reqs();
        #1;
        chk("midreset_ram_write_en", {30'd0, bus.ram_write_en}, 32'h0);
        chk("midreset_ram_addr", {18'd0, bus.ram_addr}, 32'h0);
        chk("midreset_rd_valid", {30'd0, bus.b_rd_valid, bus.a_rd_valid}, 32'h0);
        exp_addr = '0; exp_din = '0; exp_we = '0;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        idle(); idle(); idle(); idle();

        // Fixed priority with a starvation limit of 3: A,A,A,B repeating.
        @(posedge clk); #1;
        bus2.a_req = 1'b1; bus2.b_req = 1'b1;
        bus2.a_addr = 14'h0003; bus2.b_addr = 14'h0004;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("fp_grant", {30'd0, bus2.b_grant, bus2.a_grant}, (i % 4 == 3) ? 32'h2 : 32'h1);
            chk("fp_starve_cnt", {24'd0, dut2.starve_cnt}, i % 4);
        end
        @(posedge clk); #1;
        bus2.a_req = 1'b0; bus2.b_req = 1'b0;
        @(negedge clk);

        chk("reads_outstanding", sb.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester arbiter and sequencer for the byte-writable `single_port_ram`. It sits between the RAM and two masters: port A (instruction fetch) and port B (data / loader). Each cycle it grants at most one request and registers the winning command into the RAM. It tracks in-flight reads so that each read result returns only to the requester that issued it. Arbitration is either round-robin or fixed-priority with a starvation guard.

## Interface
- `ADDR_WIDTH`, default 14: RAM word-address width.
- `DATA_WIDTH`, default 16: RAM data width; a multiple of 8.
- `FIXED_PRIO_A`, default 0:
  - 0 = round-robin.
  - 1 = A has priority, subject to the `MAX_WAIT` guard.
- `MAX_WAIT`, default 7: in fixed-priority mode, the number of consecutive cycles B may be denied before it is forced a grant. Range 1..255.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `a_req`  in  1  A request. Held with stable `a_addr`/`a_din`/`a_write_en` until granted.
- `a_addr`  in  ADDR_WIDTH  A word address.
- `a_din`  in  DATA_WIDTH  A write data.
- `a_write_en`  in  DATA_WIDTH/8  A byte write mask; all-zero = read.
- `a_grant`  out  1  combinational. High in the cycle A's request is accepted.
- `a_rd_valid`  out  1  A read data valid on `a_dout`.
- `a_dout`  out  DATA_WIDTH  read data to A.
- `b_req`, `b_addr`, `b_din`, `b_write_en`, `b_grant`, `b_rd_valid`, `b_dout`: same as the A signals, for port B.
- `ram_addr`  out  ADDR_WIDTH  registered RAM address.
- `ram_din`  out  DATA_WIDTH  registered RAM write data.
- `ram_write_en`  out  DATA_WIDTH/8  registered RAM byte enables.
- `ram_dout`  in  DATA_WIDTH  RAM read data. Valid the cycle after the RAM samples `ram_addr`.

## Operation
**Arbitration (combinational in cycle N)**
- Only `a_req` high: A wins.
- Only `b_req` high: B wins.
- Both high, round-robin mode: the requester that did not win last wins. `last_win` updates only on a grant.
- Both high, fixed-priority mode: A wins, unless `starve_cnt == MAX_WAIT`, in which case B wins.
- Neither high: no grant.
- `a_grant` and `b_grant` are never high together.

**Command stage (edge ending cycle N)**
- On a grant: the winner's `addr`/`din`/`write_en` are loaded into the `ram_*` registers.
- No grant: `ram_write_en` is loaded with 0; `ram_addr` and `ram_din` hold their values.

**Read tracking**
- A 2-stage tag pipe carries {is_read, owner}.
- Stage 1 is loaded at the same edge as the command stage; stage 2 follows one cycle later.
- `x_rd_valid` = stage-2 is_read and owner == x. It is registered.

**Data return**
- `a_dout` and `b_dout` are both driven directly by `ram_dout`.
- Consumers qualify the data with `x_rd_valid` only.

**Starvation counter** (8-bit, fixed-priority mode only)
- Increments while `b_req` is high and B is not granted.
- Clears when B is granted or `b_req` is low.
- Saturates at `MAX_WAIT`.
- Held at 0 in round-robin mode.

**Writes and read-after-write**
- Writes produce no `rd_valid`.
- A read granted in the cycle after a write to the same address returns the new data, because the RAM orders the accesses.

## Timing
- Throughput: one access per cycle total. Back-to-back grants alternate under contention in round-robin mode.
- Read latency: grant in cycle N → `ram_addr` valid in N+1 → `x_rd_valid` and data valid in N+2.
- Write: grant in N → `ram_write_en` asserted in cycle N+1 only.
- Requesters may change `req`/`addr` in cycle N+1 after a grant. Keeping `req` high requests a new access.

**Reset** (asynchronous, takes effect immediately)
- `ram_addr`, `ram_din` = 0.
- `ram_write_en` = 0.
- Both tag stages = not-read, so both `rd_valid` outputs = 0.
- `last_win` = B, so A wins the first contention.
- `starve_cnt` = 0.
- Reads in flight when reset is applied are dropped. No `rd_valid` appears for them after reset is released.
- Grants are combinational from `req` and are forced to 0 while `reset` is high.

## Test plan
- **Reset:**
  - Stimulus: assert `reset` mid-read (`a_req` granted with address 0x0010 the cycle before).
  - Required response: `ram_write_en` = 0 and both `rd_valid` = 0 immediately; no `a_rd_valid` after release.
- **Single read:**
  - Stimulus: RAM preloaded so word 0x0123 = 0xBEEF; `a_req` with `a_addr` = 0x0123, mask 0 in cycle N.
  - Required response: `a_grant` in N, `ram_addr` = 0x0123 in N+1, `a_rd_valid` = 1 and `a_dout` = 0xBEEF in N+2, `b_rd_valid` = 0 throughout.
- **Round-robin contention:**
  - Stimulus: `a_req` and `b_req` both held high for 6 cycles, reads of 0x0001 and 0x0002.
  - Required response: grants A,B,A,B,A,B; `rd_valid` follows the same owner sequence 2 cycles later with the correct data.
- **Byte write, then read:**
  - Stimulus: from B, write 0x00AA with mask 2'b01 to 0x0040 (previously 0x1234), then read 0x0040.
  - Required response: `b_rd_valid` with `b_dout` = 0x12AA.
- **Fixed priority with `MAX_WAIT` = 3:**
  - Stimulus: both requests held continuously.
  - Required response: grant pattern A,A,A,B repeating. `starve_cnt` reads 0,1,2,3,0.
- **Idle gaps:**
  - Stimulus: alternate single-cycle A writes with idle cycles.
  - Required response: `ram_write_en` is nonzero only in the cycle after each grant; `ram_addr` holds its value during idle cycles.
